// File: rtl/countdown_6_pkg.sv
// rtl/countdown_6_pkg.sv - shared control constants for the multi-cycle units
package countdown_6_pkg;

  localparam int COUNT_WIDTH = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

endpackage

// File: rtl/countdown_6_if.sv
// rtl/countdown_6_if.sv - iteration-count interface between controller and counter
interface countdown_6_if import countdown_6_pkg::*; #(
  parameter int WIDTH = COUNT_WIDTH
);

  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output load, load_value, enable, abort,
    input  count, busy, done, zero
  );

  modport slave (
    input  load, load_value, enable, abort,
    output count, busy, done, zero
  );

endinterface

// File: rtl/countdown_6_tff_sync.sv
// rtl/countdown_6_tff_sync.sv - T flip-flop with synchronous active-high reset
module tff_sync (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  // Toggle on t, clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/countdown_6.sv
// rtl/countdown_6.sv - loadable down counter with busy/done handshake
module countdown_6 import countdown_6_pkg::*; #(
  parameter int WIDTH = COUNT_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  countdown_6_if.slave  bus
);

  run_state_t       state;
  logic             done_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] toggle;
  logic             borrow;

  // Select per-bit toggles: abort clears, load steers to load_value, run walks the borrow chain.
  always_comb begin
    toggle = '0;
    borrow = 1'b1;
    if (bus.abort) begin
      toggle = count_q;
    end else if (bus.load) begin
      toggle = count_q ^ bus.load_value;
    end else if (state == ST_RUN && bus.enable) begin
      for (int i = 0; i < WIDTH; i++) begin
        toggle[i] = borrow;
        borrow    = borrow & ~count_q[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      tff_sync u_tff (
        .clk   (clk),
        .reset (reset),
        .t     (toggle[gi]),
        .q     (count_q[gi])
      );
    end
  endgenerate

  // Run/idle control and the one-cycle done pulse; count==1 under enable is the last step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      done_q <= 1'b0;
    end else if (bus.abort) begin
      state  <= ST_IDLE;
      done_q <= 1'b0;
    end else if (bus.load) begin
      if (bus.load_value != '0) begin
        state  <= ST_RUN;
        done_q <= 1'b0;
      end else begin
        state  <= ST_IDLE;
        done_q <= 1'b1;
      end
    end else if (state == ST_RUN && bus.enable && count_q == WIDTH'(1)) begin
      state  <= ST_IDLE;
      done_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state == ST_RUN);
  assign bus.done  = done_q;
  assign bus.zero  = (count_q == '0);

endmodule
